// File: rtl/eprisc_rom_fetch_pkg.sv
// Shared widths, reset vector default and the queue entry type for the epRISC fetch stage.
package eprisc_fetch_pkg;

  localparam int unsigned    DEFAULT_AW           = 8;
  localparam int unsigned    DEFAULT_DW           = 32;
  localparam logic [7:0]     DEFAULT_RESET_VECTOR = 8'h00;

  typedef struct packed {
    logic [DEFAULT_AW-1:0] addr;
    logic [DEFAULT_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/eprisc_rom_fetch_if.sv
// Fetch-to-decoder handshake: instruction, its word address, valid/ready.
interface eprisc_rom_fetch_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic [DW-1:0] oInstr;
  logic [AW-1:0] oInstrAddr;
  logic          oValid;
  logic          iReady;

  modport master (output oInstr, output oInstrAddr, output oValid, input iReady);
  modport slave  (input oInstr, input oInstrAddr, input oValid, output iReady);
endinterface

// File: rtl/eprisc_rom_fetch_fifo.sv
// In-order prefetch queue with a registered head (entry 0) and flush that beats push/pop.
module eprisc_fetch_fifo
  import eprisc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         ENTRY_T = fetch_entry_t,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  ENTRY_T        push_data_i,
  input  logic          pop_i,
  output ENTRY_T        head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  ENTRY_T [DEPTH-1:0] mem_q, mem_d;
  logic [CW-1:0]      count_q, count_d, wr_idx;
  logic               valid_q, pop_eff;

  assign pop_eff = pop_i && valid_q;
  assign wr_idx  = count_q - CW'(pop_eff);

  // Entries shift towards slot 0 on pop so the head is always a plain flop.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (pop_eff) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          mem_d[i] = mem_q[i+1];
        end
      end
      if (push_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) begin
            mem_d[i] = push_data_i;
          end
        end
      end
      count_d = count_q + CW'(push_i) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign head_o  = mem_q[0];
  assign valid_o = valid_q;
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_eff && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/eprisc_rom_fetch.sv
// epRISC boot-ROM fetch stage: PC, issue throttling, in-flight tracking and prefetch queue.
module eprisc_rom_fetch
  import eprisc_fetch_pkg::*;
#(
  parameter int unsigned   AW           = DEFAULT_AW,
  parameter int unsigned   DW           = DEFAULT_DW,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(DEFAULT_RESET_VECTOR),
  parameter int unsigned   DEPTH        = 2
) (
  input  logic                    iClk,
  input  logic                    iReset_n,
  output logic [AW-1:0]           oRomAddr,
  output logic                    oRomEnable,
  input  logic [DW-1:0]           iRomData,
  input  logic                    iRedirect,
  input  logic [AW-1:0]           iRedirectAddr,
  eprisc_rom_fetch_if.master      dec
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] instr;
  } entry_t;

  logic [AW-1:0] pc_q, pc_d, inflight_addr_q, inflight_addr_d;
  logic          en_q, inflight_q, inflight_d;
  logic          pop, issue;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  entry_t        push_entry, head;

  assign pop = dec.oValid && dec.iReady;

  // Slots committed after this edge: queued + returning word - departing head.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = en_q && !iRedirect && (occupancy < (CW+1)'(DEPTH));

  always_comb begin
    pc_d            = pc_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    if (iRedirect) begin
      pc_d       = iRedirectAddr;
      inflight_d = 1'b0;
    end else if (issue) begin
      pc_d            = pc_q + AW'(1);
      inflight_addr_d = pc_q;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      pc_q            <= RESET_VECTOR;
      en_q            <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      en_q            <= 1'b1;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  assign push_entry = '{addr: inflight_addr_q, instr: iRomData};

  eprisc_fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk_i       (iClk),
    .rst_ni      (iReset_n),
    .flush_i     (iRedirect),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (dec.oValid),
    .count_o     (count)
  );

  assign oRomAddr       = pc_q;
  assign oRomEnable     = en_q;
  assign dec.oInstr     = head.instr;
  assign dec.oInstrAddr = head.addr;

endmodule

// File: tb/tb_eprisc_rom_fetch.sv
// Bench for eprisc_rom_fetch: queue-based reference model checked every cycle plus literal transfer checks.
module tb_eprisc_rom_fetch;

  localparam int DEPTH = 2;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic [7:0]  oRomAddr;
  logic        oRomEnable;
  logic [31:0] iRomData;
  logic        iRedirect = 1'b0;
  logic [7:0]  iRedirectAddr = 8'h00;

  eprisc_rom_fetch_if #(.AW(8), .DW(32)) dec_if ();

  eprisc_rom_fetch #(
    .AW           (8),
    .DW           (32),
    .RESET_VECTOR (8'h00),
    .DEPTH        (DEPTH)
  ) dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .oRomAddr      (oRomAddr),
    .oRomEnable    (oRomEnable),
    .iRomData      (iRomData),
    .iRedirect     (iRedirect),
    .iRedirectAddr (iRedirectAddr),
    .dec           (dec_if)
  );

  always #5 iClk = ~iClk;

  // Boot ROM: 1-cycle registered read, drives data only while enabled.
  logic [31:0] rom [256];
  logic [31:0] rom_q;
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | i;
    rom[0]  = 32'h2441_3345;
    rom[1]  = 32'h2500_0000;
    rom[2]  = 32'h2600_0200;
    rom[35] = 32'h0420_0000;
  end
  always @(posedge iClk) rom_q <= rom[oRomAddr];
  assign iRomData = oRomEnable ? rom_q : 'x;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: PC, enable, one returning address, FIFO of queued addresses.
  int cyc = 0;
  int m_pc;
  bit m_en;
  bit m_inf;
  int m_inf_addr;
  int m_q[$];
  bit m_pop;
  bit m_iss;
  int m_room;

  task automatic m_reset();
    m_pc  = 0;
    m_en  = 1'b0;
    m_inf = 1'b0;
    m_q.delete();
  endtask

  always @(negedge iReset_n) m_reset();

  always @(posedge iClk) begin
    cyc++;
    if (!iReset_n) begin
      m_reset();
    end else begin
      m_pop = (m_q.size() != 0) && dec_if.iReady;
      if (iRedirect) begin
        m_q.delete();
        m_inf = 1'b0;
        m_pc  = iRedirectAddr;
      end else begin
        m_room = m_q.size() + int'(m_inf) - int'(m_pop);
        m_iss  = m_en && (m_room < DEPTH);
        if (m_pop) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_inf_addr);
        m_inf = m_iss;
        if (m_iss) begin
          m_inf_addr = m_pc;
          m_pc = (m_pc + 1) % 256;
        end
      end
      m_en = 1'b1;
    end
  end

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] instr;
  } xfer_t;
  xfer_t log_q[$];
  xfer_t x;

  always @(negedge iClk) begin
    if (!iReset_n) begin
      chk("rst_valid", dec_if.oValid, 1'b0);
      chk("rst_romen", oRomEnable, 1'b0);
      chk("rst_romaddr", oRomAddr, 8'h00);
      chk("rst_instr", dec_if.oInstr, 32'h0);
      chk("rst_iaddr", dec_if.oInstrAddr, 8'h00);
    end else begin
      chk("romen", oRomEnable, m_en);
      chk("romaddr", oRomAddr, m_pc[7:0]);
      chk("valid", dec_if.oValid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("instr_addr", dec_if.oInstrAddr, m_q[0]);
        chk("instr", dec_if.oInstr, rom[m_q[0]]);
      end
      if (dec_if.oValid && dec_if.iReady && !iRedirect) begin
        x.cyc = cyc; x.addr = dec_if.oInstrAddr; x.instr = dec_if.oInstr;
        log_q.push_back(x);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iClk);
      #2;
    end
  endtask

  task automatic exp_log(input string nm, input int idx, input int c, input logic [7:0] a,
                         input logic [31:0] ins);
    if (idx >= log_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s missing transfer idx=%0d have=%0d", nm, idx, log_q.size());
    end else begin
      chk({nm, "_cyc"}, log_q[idx].cyc, c);
      chk({nm, "_addr"}, log_q[idx].addr, a);
      chk({nm, "_instr"}, log_q[idx].instr, ins);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  int rel, base, t0, r;

  initial begin
    dec_if.iReady = 1'b1;
    step(3);

    // Test 1: boot sequence, oValid three edges after release
    iReset_n = 1'b1;
    rel = cyc;
    base = log_q.size();
    step(6);
    exp_log("t1_w0", base + 0, rel + 3, 8'h00, 32'h2441_3345);
    exp_log("t1_w1", base + 1, rel + 4, 8'h01, 32'h2500_0000);
    exp_log("t1_w2", base + 2, rel + 5, 8'h02, 32'h2600_0200);

    // Test 2: decoder stall fills the queue and freezes the PC
    dec_if.iReady = 1'b0;
    step(10);
    chk("t2_romaddr_frozen", oRomAddr, 8'h05);
    chk("t2_valid", dec_if.oValid, 1'b1);
    chk("t2_head_addr", dec_if.oInstrAddr, 8'h03);
    chk("t2_head_instr", dec_if.oInstr, 32'hA500_0003);
    dec_if.iReady = 1'b1;
    t0 = cyc;
    base = log_q.size();
    step(4);
    exp_log("t2_a", base + 0, t0 + 0, 8'h03, 32'hA500_0003);
    exp_log("t2_b", base + 1, t0 + 1, 8'h04, 32'hA500_0004);
    exp_log("t2_c", base + 2, t0 + 2, 8'h05, 32'hA500_0005);
    exp_log("t2_d", base + 3, t0 + 3, 8'h06, 32'hA500_0006);

    // Test 3: redirect to 0x23 with a full queue
    dec_if.iReady = 1'b0;
    step(4);
    iRedirect = 1'b1;
    iRedirectAddr = 8'h23;
    dec_if.iReady = 1'b1;
    r = cyc;
    base = log_q.size();
    step(1);
    iRedirect = 1'b0;
    iRedirectAddr = 8'h77;
    step(5);
    exp_log("t3_tgt", base + 0, r + 3, 8'h23, 32'h0420_0000);
    exp_log("t3_next", base + 1, r + 4, 8'h24, 32'hA500_0024);

    // Test 4: redirect near the top of the address space wraps to 0
    iRedirect = 1'b1;
    iRedirectAddr = 8'hFE;
    r = cyc;
    base = log_q.size();
    step(1);
    iRedirect = 1'b0;
    step(7);
    exp_log("t4_fe", base + 0, r + 3, 8'hFE, 32'hA500_00FE);
    exp_log("t4_ff", base + 1, r + 4, 8'hFF, 32'hA500_00FF);
    exp_log("t4_00", base + 2, r + 5, 8'h00, 32'h2441_3345);
    exp_log("t4_01", base + 3, r + 6, 8'h01, 32'h2500_0000);

    // Test 5: redirect coinciding with a handshake is not a transfer
    chk("t5_valid_before", dec_if.oValid, 1'b1);
    iRedirect = 1'b1;
    iRedirectAddr = 8'h10;
    r = cyc;
    base = log_q.size();
    step(1);
    iRedirect = 1'b0;
    step(2);
    chk("t5_no_transfer", log_q.size(), base);
    step(3);
    exp_log("t5_tgt", base + 0, r + 3, 8'h10, 32'hA500_0010);
    exp_log("t5_next", base + 1, r + 4, 8'h11, 32'hA500_0011);

    // Test 6: asynchronous reset pulse mid-stream
    iReset_n = 1'b0;
    #1;
    chk("t6_valid", dec_if.oValid, 1'b0);
    chk("t6_romen", oRomEnable, 1'b0);
    chk("t6_romaddr", oRomAddr, 8'h00);
    chk("t6_instr", dec_if.oInstr, 32'h0);
    chk("t6_iaddr", dec_if.oInstrAddr, 8'h00);
    #1;
    iReset_n = 1'b1;
    rel = cyc;
    base = log_q.size();
    step(6);
    exp_log("t6_w0", base + 0, rel + 3, 8'h00, 32'h2441_3345);
    exp_log("t6_w1", base + 1, rel + 4, 8'h01, 32'h2500_0000);
    exp_log("t6_w2", base + 2, rel + 5, 8'h02, 32'h2600_0200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
